sdram_traffic_gen: RTL and testbench

Parametrised Avalon-MM master that generates write or read-verify traffic to the HPS FPGA-to-SDRAM port for bandwidth and integrity testing. Successor to the fixed single-beat write tester: adds configurable data/address width, burst transfers with a short final burst, and a read-back mode that checks the written pattern and counts mismatches. It sits between the CPU control/status register file (run strobe, base, size, burst length, mode in; busy, cycle count, error count out) and the `sdram0` Avalon port of the SoC.

---
 rtl/sdram_traffic_gen_if.sv | 26 ++
 rtl/sdram_traffic_gen.sv | 144 ++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_traffic_gen_if.sv
// Avalon-MM bus between the traffic generator (master) and the SDRAM port (slave).
interface sdram_traffic_gen_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 28,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, burstcount, write, writedata, byteenable, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, write, writedata, byteenable, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// Burst write / read-verify traffic generator for the HPS FPGA-to-SDRAM port.
// Optional macro TRAFFIC_GEN_ERR_CAPTURE_EN enables first-mismatch address capture.
module sdram_traffic_gen #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 28,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_stb_i,
  input  logic               mode_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  input  logic [CNT_W-1:0]   size_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [ADDR_W-1:0]  first_err_addr_o,
  sdram_traffic_gen_if.master amm
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [BURST_W-1:0] MAX_B = {1'b1, {(BURST_W-1){1'b0}}};

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_BURST = 3'd1;
  localparam logic [2:0] RD_REQ   = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   k;
  logic [BURST_W-1:0] blen;
  logic [BURST_W-1:0] beat;
  logic [BURST_W-1:0] burst_b;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic               start, beat_acc, beat_end, run_end, err_hit;

  function automatic logic [DATA_W-1:0] pattern(input logic [CNT_W-1:0] idx);
    logic [HALF_W-1:0] lo;
    lo = HALF_W'(idx);
    return {~lo, lo};
  endfunction

  function automatic logic [BURST_W-1:0] clamp_blen(input logic [BURST_W-1:0] v);
    if (v == '0)   return BURST_W'(1);
    if (v > MAX_B) return MAX_B;
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // remaining only moves at burst boundaries, so burst_b is stable across a burst
  assign burst_b  = (remaining < CNT_W'(blen)) ? BURST_W'(remaining) : blen;
  assign start    = (state == IDLE) && run_stb_i;
  assign beat_acc = ((state == WR_BURST) && !amm.waitrequest) ||
                    ((state == RD_WAIT) && amm.readdatavalid);
  assign beat_end = beat_acc && (beat == burst_b - BURST_W'(1));
  assign run_end  = beat_end && (remaining == CNT_W'(burst_b));
  assign err_hit  = (state == RD_WAIT) && amm.readdatavalid && (amm.readdata != pattern(k));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (run_stb_i) state_nxt = (size_i == '0) ? DONE : (mode_i ? RD_REQ : WR_BURST);
      WR_BURST: if (run_end) state_nxt = DONE;
      RD_REQ:   if (!amm.waitrequest) state_nxt = RD_WAIT;
      RD_WAIT:  if (run_end) state_nxt = DONE;
                else if (beat_end) state_nxt = RD_REQ;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      k         <= '0;
      blen      <= '0;
      beat      <= '0;
      cycle_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state != IDLE) cycle_cnt <= cycle_cnt + 1'b1;
      if (start) begin
        addr      <= base_addr_i;
        remaining <= size_i;
        blen      <= clamp_blen(burst_len_i);
        k         <= '0;
        beat      <= '0;
        cycle_cnt <= '0;
        err_cnt   <= '0;
      end
      if (beat_acc) begin
        k <= k + 1'b1;
        if (beat_end) begin
          beat      <= '0;
          remaining <= remaining - CNT_W'(burst_b);
          if (!run_end) addr <= addr + ADDR_W'(burst_b);
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (err_hit) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef TRAFFIC_GEN_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] first_err;

  // err_cnt still zero marks the first mismatch of the run
  always_ff @(posedge clk_i) begin
    if (rst_i || start)             first_err <= '0;
    else if (err_hit && err_cnt == '0) first_err <= addr + ADDR_W'(beat);
  end

  assign first_err_addr_o = first_err;
`else
  assign first_err_addr_o = '0;
`endif

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign cycle_cnt_o = cycle_cnt;
  assign err_cnt_o   = err_cnt;

  assign amm.write      = (state == WR_BURST);
  assign amm.read       = (state == RD_REQ);
  assign amm.address    = (amm.write || amm.read) ? addr : '0;
  assign amm.burstcount = (amm.write || amm.read) ? burst_b : '0;
  assign amm.writedata  = amm.write ? pattern(k) : '0;
  assign amm.byteenable = '1;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen: write bursts, stalls, read-verify, size 0, reset mid-run.
module tb_sdram_traffic_gen;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         run_stb_i = 1'b0;
  logic         mode_i = 1'b0;
  logic [27:0]  base_addr_i = '0;
  logic [31:0]  size_i = '0;
  logic [7:0]   burst_len_i = '0;
  logic         busy_o, done_o;
  logic [31:0]  cycle_cnt_o, err_cnt_o;
  logic [27:0]  first_err_addr_o;

  sdram_traffic_gen_if #(.DATA_W(128), .ADDR_W(28), .BURST_W(8)) amm ();

  sdram_traffic_gen #(.DATA_W(128), .ADDR_W(28), .BURST_W(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_stb_i(run_stb_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .size_i(size_i), .burst_len_i(burst_len_i),
    .busy_o(busy_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .amm(amm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc, n_wr, done_cnt, done_cyc, last_acc_cyc, last_rv_cyc, n_rd_req, pend, rk;
  int bus_cycles, stall_beat, stall_left, stall_seen, stall_bad, strobe_cyc;
  logic [31:0]  corrupt;
  logic [27:0]  wr_addr [0:31];
  logic [7:0]   wr_bc   [0:31];
  logic [127:0] wr_data [0:31];
  logic [27:0]  rd_addr0, stall_addr;
  logic [7:0]   rd_bc0;
  logic [127:0] stall_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int idx);
    logic [63:0] lo;
    lo = 64'(idx);
    return {~lo, lo};
  endfunction

  task automatic clear_log();
    n_wr = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; last_rv_cyc = -1;
    n_rd_req = 0; pend = 0; rk = 0; bus_cycles = 0;
    stall_beat = -1; stall_left = 0; stall_seen = 0; stall_bad = 0; corrupt = '0;
  endtask

  // One clock: observe outputs of the current cycle, then drive the slave side for it.
  task automatic step();
    @(negedge clk);
    cyc++;
    run_stb_i = 1'b0;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (amm.write || amm.read) bus_cycles++;
    if (pend > 0) begin
      amm.readdatavalid = 1'b1;
      amm.readdata = pat(rk) ^ (corrupt[rk[4:0]] ? 128'h1 : 128'h0);
      last_rv_cyc = cyc;
      pend--; rk++;
    end else begin
      amm.readdatavalid = 1'b0;
      amm.readdata = '0;
    end
    amm.waitrequest = 1'b0;
    if (amm.write && n_wr == stall_beat && stall_seen > 0) begin
      if (amm.address !== stall_addr || amm.writedata !== stall_data) stall_bad++;
    end
    if (amm.write && n_wr == stall_beat && stall_left > 0) begin
      if (stall_seen == 0) begin stall_addr = amm.address; stall_data = amm.writedata; end
      stall_seen++; stall_left--;
      amm.waitrequest = 1'b1;
    end
    if (amm.write && !amm.waitrequest && n_wr < 32) begin
      wr_addr[n_wr] = amm.address; wr_bc[n_wr] = amm.burstcount; wr_data[n_wr] = amm.writedata;
      n_wr++; last_acc_cyc = cyc;
    end
    if (amm.read && !amm.waitrequest) begin
      if (n_rd_req == 0) begin rd_addr0 = amm.address; rd_bc0 = amm.burstcount; end
      n_rd_req++;
      pend += int'(amm.burstcount);
    end
  endtask

  task automatic start(input logic m, input logic [27:0] base, input logic [31:0] sz, input logic [7:0] bl);
    step();
    run_stb_i = 1'b1; mode_i = m; base_addr_i = base; size_i = sz; burst_len_i = bl;
    strobe_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    check({tag, "_done_seen"}, 128'(done_cnt), 128'd1);
    step();
    check({tag, "_busy_low"}, 128'(busy_o), 128'd0);
  endtask

  initial begin
    amm.waitrequest = 1'b0; amm.readdata = '0; amm.readdatavalid = 1'b0;
    cyc = 0;
    clear_log();

    // reset state
    repeat (3) step();
    rst_i = 1'b0;
    step();
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_write", 128'(amm.write), 128'd0);
    check("rst_read", 128'(amm.read), 128'd0);
    check("rst_be", 128'(amm.byteenable), 128'hFFFF);
    check("rst_cycle", 128'(cycle_cnt_o), 128'd0);
    check("rst_err", 128'(err_cnt_o), 128'd0);

    // write 10 beats in bursts of 4
    clear_log();
    start(1'b0, 28'h100, 32'd10, 8'd4);
    step();
    check("w1_first_write", 128'(amm.write), 128'd1);
    wait_done("w1", 100);
    check("w1_beats", 128'(n_wr), 128'd10);
    check("w1_addr0", 128'(wr_addr[0]), 128'h100);
    check("w1_addr3", 128'(wr_addr[3]), 128'h100);
    check("w1_addr4", 128'(wr_addr[4]), 128'h104);
    check("w1_addr8", 128'(wr_addr[8]), 128'h108);
    check("w1_bc0", 128'(wr_bc[0]), 128'd4);
    check("w1_bc4", 128'(wr_bc[4]), 128'd4);
    check("w1_bc9", 128'(wr_bc[9]), 128'd2);
    check("w1_data5", wr_data[5], 128'hFFFFFFFFFFFFFFFA_0000000000000005);
    check("w1_data9", wr_data[9], 128'hFFFFFFFFFFFFFFF6_0000000000000009);
    check("w1_done_lat", 128'(done_cyc - last_acc_cyc), 128'd1);
    check("w1_cycles", 128'(cycle_cnt_o), 128'd11);

    // single-beat writes with a 3-cycle stall on beat 2
    clear_log();
    stall_beat = 2; stall_left = 3;
    start(1'b0, 28'h200, 32'd8, 8'd0);
    wait_done("w2", 100);
    check("w2_beats", 128'(n_wr), 128'd8);
    check("w2_bc7", 128'(wr_bc[7]), 128'd1);
    check("w2_addr7", 128'(wr_addr[7]), 128'h207);
    check("w2_data2", wr_data[2], 128'hFFFFFFFFFFFFFFFD_0000000000000002);
    check("w2_stall_seen", 128'(stall_seen), 128'd3);
    check("w2_stall_hold", 128'(stall_bad), 128'd0);
    check("w2_cycles", 128'(cycle_cnt_o), 128'd12);

    // clean read-verify, one burst of 8
    clear_log();
    start(1'b1, 28'h300, 32'd8, 8'd8);
    wait_done("r1", 100);
    check("r1_reqs", 128'(n_rd_req), 128'd1);
    check("r1_bc", 128'(rd_bc0), 128'd8);
    check("r1_addr", 128'(rd_addr0), 128'h300);
    check("r1_err", 128'(err_cnt_o), 128'd0);
    check("r1_done_lat", 128'(done_cyc - last_rv_cyc), 128'd1);
    check("r1_cycles", 128'(cycle_cnt_o), 128'd10);

    // read with beats 3 and 6 corrupted, bursts of 4
    clear_log();
    corrupt = 32'h48;
    start(1'b1, 28'h400, 32'd8, 8'd4);
    wait_done("r2", 100);
    check("r2_reqs", 128'(n_rd_req), 128'd2);
    check("r2_err", 128'(err_cnt_o), 128'd2);
`ifdef TRAFFIC_GEN_ERR_CAPTURE_EN
    check("r2_first_err", 128'(first_err_addr_o), 128'h403);
`else
    check("r2_first_err", 128'(first_err_addr_o), 128'h0);
`endif

    // size 0, plus a strobe while busy that must be ignored
    clear_log();
    start(1'b0, 28'h600, 32'd0, 8'd4);
    step();
    check("z_done_now", 128'(done_o), 128'd1);
    run_stb_i = 1'b1; mode_i = 1'b1; size_i = 32'd5;
    repeat (5) step();
    check("z_done_lat", 128'(done_cyc - strobe_cyc), 128'd1);
    check("z_done_cnt", 128'(done_cnt), 128'd1);
    check("z_no_bus", 128'(bus_cycles), 128'd0);
    check("z_cycles", 128'(cycle_cnt_o), 128'd1);
    check("z_idle", 128'(busy_o), 128'd0);

    // reset during a write burst
    clear_log();
    start(1'b0, 28'h500, 32'd10, 8'd4);
    for (int i = 0; i < 50 && n_wr < 2; i++) step();
    step();
    rst_i = 1'b1;
    step();
    check("rr_write", 128'(amm.write), 128'd0);
    check("rr_busy", 128'(busy_o), 128'd0);
    rst_i = 1'b0;
    repeat (5) step();
    check("rr_no_done", 128'(done_cnt), 128'd0);
    check("rr_cycles", 128'(cycle_cnt_o), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
